ccd_clk_timing: RTL and testbench

Parametrised linear-CCD timing generator for the spectrometer front end. It produces a runtime-programmable master clock `ccd_m` from `clk_50m` with an exact 50 % duty cycle for odd and even divisors. On top of that clock it sequences the ICG/SH frame pulses, applies a programmable integration time, and issues one `clk_50m`-wide pixel strobe per output pixel for the ADC capture path. It replaces the fixed divide-by-25 master-clock generator.

---
 rtl/ccd_clk_timing.sv | 116 +++++++++++
 tb/tb_ccd_clk_timing.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ccd_clk_timing.sv
// ccd_clk_timing: runtime-divisible 50 % duty CCD master clock plus ICG/SH frame
// sequencing, programmable integration period and per-pixel ADC strobes.
module ccd_clk_timing #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 25,
  parameter int PIX_W   = 12,
  parameter int NUM_PIX = 3694,
  parameter int INT_W   = 24
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  input  logic [INT_W-1:0] int_time,
  input  logic             start,
  input  logic             stop,
  output logic             ccd_m,
  output logic             ccd_icg,
  output logic             ccd_sh,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_idx,
  output logic             frame_done,
  output logic             busy
);
  localparam logic [INT_W-1:0] MIN_PER = INT_W'(8 + 4 * NUM_PIX);
  typedef enum logic [2:0] {IDLE, LEAD, SHP, TAIL, READ, WAIT} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, pend_q, cnt_q, cnt_d;
  logic pend_vld_q, a_q, b_q, m_tick, start_q, stop_q;
  logic [INT_W-1:0] ftick_q, ftick_d, ftick_inc, per_q, per_d, per_new;
  logic [PIX_W+1:0] rel;
  logic [PIX_W-1:0] pix, pix_d;
  logic icg_d, sh_d, pv_d, fd_d;
  assign m_tick = cnt_q == div_q - DIV_W'(1);
  assign cnt_d = m_tick ? '0 : cnt_q + DIV_W'(1);
  assign div_d = m_tick && pend_vld_q ? pend_q : div_q;
  assign ccd_m = a_q | b_q;
  assign busy = state_q != IDLE;
  // a new divisor only takes effect at a period wrap, so no runt periods appear
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      div_q <= DIV_W'(DEF_DIV);
      pend_q <= DIV_W'(DEF_DIV);
      pend_vld_q <= 1'b0;
      cnt_q <= '0;
      a_q <= 1'b1;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      a_q <= cnt_d < (div_d >> 1);
      if (div_load) pend_q <= div_in < DIV_W'(2) ? DIV_W'(2) : div_in;
      pend_vld_q <= div_load | (pend_vld_q & ~m_tick);
    end
  end
  // half-cycle extension of phase A gives the extra half period for odd divisors
  always_ff @(negedge clk_50m or negedge rst) begin
    if (!rst) b_q <= 1'b0;
    else b_q <= a_q & div_q[0];
  end
  assign ftick_inc = ftick_q + INT_W'(1);
  assign per_new = int_time > MIN_PER ? int_time : MIN_PER;
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ftick_q <= '0;
      per_q <= MIN_PER;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      ccd_icg <= 1'b1;
      ccd_sh <= 1'b0;
      pix_valid <= 1'b0;
      pix_idx <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q <= state_d;
      ftick_q <= ftick_d;
      per_q <= per_d;
      start_q <= state_q == IDLE && (start || (start_q && !m_tick));
      stop_q <= (state_d == IDLE && state_q != IDLE) ? 1'b0 : stop ? 1'b1 :
                (state_q == IDLE && !start_q) ? 1'b0 : stop_q;
      ccd_icg <= icg_d;
      ccd_sh <= sh_d;
      pix_valid <= pv_d;
      pix_idx <= pix_d;
      frame_done <= fd_d;
    end
  end
  // state_q always names the phase owning the most recent frame tick
  always_comb begin
    state_d = state_q;
    ftick_d = ftick_q;
    per_d = per_q;
    if (m_tick && state_q == IDLE && start_q) begin
      state_d = LEAD;
      ftick_d = '0;
      per_d = per_new;
    end else if (m_tick && state_q != IDLE) begin
      ftick_d = ftick_inc == per_q ? '0 : ftick_inc;
      per_d = ftick_inc == per_q ? per_new : per_q;
      state_d = ftick_inc == per_q ? (stop_q ? IDLE : LEAD) :
                ftick_inc < INT_W'(2) ? LEAD :
                ftick_inc < INT_W'(6) ? SHP :
                ftick_inc < INT_W'(8) ? TAIL :
                ftick_inc < MIN_PER ? READ : WAIT;
    end
  end
  always_comb begin
    rel = ftick_d[PIX_W+1:0] - (PIX_W+2)'(8);
    pix = rel[PIX_W+1:2];
    icg_d = !(state_d inside {LEAD, SHP, TAIL});
    sh_d = state_d == SHP;
    pv_d = m_tick && state_d == READ && rel[1:0] == 2'd3;
    fd_d = pv_d && pix == PIX_W'(NUM_PIX - 1);
    pix_d = state_d == READ ? pix : state_d == LEAD ? '0 : pix_idx;
  end
endmodule

// File: tb/tb_ccd_clk_timing.sv
// tb_ccd_clk_timing: directed checks of master-clock divisor behaviour and frame
// tick schedule with an 8-pixel sensor.
`timescale 1ns/1ns
module tb_ccd_clk_timing;
  localparam int NP = 8;
  logic clk_50m = 1'b0, rst = 1'b1, div_load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] div_in = '0;
  logic [23:0] int_time = '0;
  logic ccd_m, ccd_icg, ccd_sh, pix_valid, frame_done, busy;
  logic [11:0] pix_idx;
  int n_run = 0, n_fail = 0;
  ccd_clk_timing #(.NUM_PIX(NP)) dut (
    .clk_50m(clk_50m), .rst(rst), .div_in(div_in), .div_load(div_load),
    .int_time(int_time), .start(start), .stop(stop), .ccd_m(ccd_m),
    .ccd_icg(ccd_icg), .ccd_sh(ccd_sh), .pix_valid(pix_valid), .pix_idx(pix_idx),
    .frame_done(frame_done), .busy(busy)
  );
  always #10 clk_50m = ~clk_50m;
  // event log indexed by ccd_m rising edge (one per master tick)
  int rises = 0;
  logic m_p = 1'b1, icg_p = 1'b1, sh_p = 1'b0;
  int q_icgf[$], q_icgr[$], q_shr[$], q_shf[$], q_pv[$], q_pvi[$], q_fd[$];
  always @(posedge clk_50m) begin
    #1;
    if (ccd_m && !m_p) rises++;
    m_p = ccd_m;
    if (!ccd_icg && icg_p) q_icgf.push_back(rises);
    if (ccd_icg && !icg_p) q_icgr.push_back(rises);
    if (ccd_sh && !sh_p) q_shr.push_back(rises);
    if (!ccd_sh && sh_p) q_shf.push_back(rises);
    icg_p = ccd_icg;
    sh_p = ccd_sh;
    if (pix_valid) begin
      q_pv.push_back(rises);
      q_pvi.push_back(int'(pix_idx));
    end
    if (frame_done) q_fd.push_back(rises);
  end
  task automatic check(input string tag, input longint got, input longint exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ccd_m"}, ccd_m, 1);
    check({tag, "_icg"}, ccd_icg, 1);
    check({tag, "_sh"}, ccd_sh, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_idx"}, pix_idx, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  task automatic pulse_div(input logic [7:0] d);
    @(negedge clk_50m);
    div_in = d;
    div_load = 1'b1;
    @(negedge clk_50m);
    div_load = 1'b0;
    #5;
  endtask
  task automatic pulse_ss(input logic s_start, input logic s_stop);
    @(negedge clk_50m);
    start = s_start;
    stop = s_stop;
    @(negedge clk_50m);
    start = 1'b0;
    stop = 1'b0;
    #5;
  endtask
  // polls on a half-cycle-offset grid so edge timing differences are exact
  task automatic wait_lvl(input logic lvl);
    int n = 0;
    while (ccd_m !== lvl && n < 2000) begin
      #10;
      n++;
    end
    if (n >= 2000) check("ccd_m_edge_timeout", 0, 1);
  endtask
  task automatic measure(output longint hi, output longint per);
    longint t0, t1;
    wait_lvl(1'b0);
    wait_lvl(1'b1);
    t0 = $time;
    wait_lvl(1'b0);
    t1 = $time;
    wait_lvl(1'b1);
    hi = t1 - t0;
    per = $time - t0;
  endtask
  initial begin
    longint hi, per, t0;
    int bad, base, r0, pvb, fdb;
    #1 rst = 1'b0;
    #24 check_reset("reset");
    @(negedge clk_50m) rst = 1'b1;
    #5;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      measure(hi, per);
      if (hi != 250 || per != 500) bad++;
    end
    check("div25_bad_periods", bad, 0);
    check("div25_high_ns", hi, 250);
    check("div25_period_ns", per, 500);
    t0 = $time;
    repeat (5) #20;
    pulse_div(8'd24);
    wait_lvl(1'b0);
    wait_lvl(1'b1);
    check("div_change_old_period_ns", $time - t0, 500);
    measure(hi, per);
    check("div24_high_ns", hi, 240);
    check("div24_period_ns", per, 480);
    pulse_div(8'd1);
    measure(hi, per);
    check("div1_clamp_high_ns", hi, 20);
    check("div1_clamp_period_ns", per, 40);
    pulse_div(8'd4);
    measure(hi, per);
    check("div4_high_ns", hi, 40);
    check("div4_period_ns", per, 80);
    int_time = 24'd100;
    base = q_icgf.size();
    pulse_ss(1'b1, 1'b0);
    for (int i = 0; i < 2000 && q_icgf.size() < base + 2; i++) @(negedge clk_50m);
    int_time = 24'd10;
    check("frame2_started", q_icgf.size(), base + 2);
    check("busy_in_frame", busy, 1);
    r0 = q_icgf[base];
    check("icg_fall_to_next_100", q_icgf[base + 1] - r0, 100);
    check("sh_rise_tick", q_shr[0] - r0, 2);
    check("sh_fall_tick", q_shf[0] - r0, 6);
    check("icg_rise_tick", q_icgr[0] - r0, 8);
    check("strobes_frame1", q_pv.size(), NP);
    for (int k = 0; k < NP; k++) begin
      check($sformatf("pix%0d_tick", k), q_pv[k] - r0, 11 + 4 * k);
      check($sformatf("pix%0d_idx", k), q_pvi[k], k);
    end
    check("frame_done_tick", q_fd[0] - r0, 39);
    check("frame_done_count", q_fd.size(), 1);
    for (int i = 0; i < 3000 && q_icgf.size() < base + 4; i++) @(negedge clk_50m);
    pvb = q_pv.size();
    fdb = q_fd.size();
    check("frame4_started", q_icgf.size(), base + 4);
    check("frame2_period_still_100", q_icgf[base + 2] - q_icgf[base + 1], 100);
    check("frame3_period_clamped_40", q_icgf[base + 3] - q_icgf[base + 2], 40);
    for (int i = 0; i < 500 && q_pv.size() < pvb + 2; i++) @(negedge clk_50m);
    pulse_ss(1'b0, 1'b1);
    pulse_ss(1'b1, 1'b0);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk_50m);
    check("stop_strobes_completed", q_pv.size() - pvb, NP);
    check("stop_frame_done_count", q_fd.size() - fdb, 1);
    check("stop_idle_busy", busy, 0);
    check("stop_idle_icg", ccd_icg, 1);
    repeat (300) @(negedge clk_50m);
    check("stop_no_new_frame", q_icgf.size(), base + 4);
    base = q_icgf.size();
    pvb = q_pv.size();
    pulse_ss(1'b1, 1'b1);
    for (int i = 0; i < 200 && !busy; i++) @(negedge clk_50m);
    check("start_stop_busy", busy, 1);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk_50m);
    repeat (300) @(negedge clk_50m);
    check("start_stop_one_frame", q_icgf.size(), base + 1);
    check("start_stop_strobes", q_pv.size() - pvb, NP);
    int_time = 24'd100;
    base = q_icgf.size();
    pulse_ss(1'b1, 1'b0);
    for (int i = 0; i < 200 && q_icgf.size() < base + 1; i++) @(negedge clk_50m);
    r0 = q_icgf[base];
    for (int i = 0; i < 500 && rises < r0 + 20; i++) @(negedge clk_50m);
    check("reached_tick20", rises - r0, 20);
    #3 rst = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clk_50m) rst = 1'b1;
    #5;
    measure(hi, per);
    check("post_reset_high_ns", hi, 250);
    check("post_reset_period_ns", per, 500);
    repeat (300) @(negedge clk_50m);
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_idle_icg", ccd_icg, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
